// File: rtl/cmd_frame_reader.sv
// Command frame reader: drains whole frames from the command FIFO into the UART TX byte engine,
// truncating frames longer than MAX_LEN and holding an idle gap after every frame.
module cmd_frame_reader #(
    parameter int WIDTH      = 8,
    parameter int MAX_LEN    = 16,
    parameter int GAP_CYCLES = 1000,
    parameter int CNTW       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic             fifo_frame_end,
    output logic             fifo_ren,
    input  logic             fifo_valid,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             tx_ready,
    output logic             tx_start,
    output logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             frame_done,
    output logic             err_trunc,
    output logic [CNTW-1:0]  frame_cnt
);

    localparam int BCW = $clog2(MAX_LEN + 1);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAITV   = 3'd2,
        ST_SEND    = 3'd3,
        ST_HOLD    = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DISCARD = 3'd6,
        ST_GAP     = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
    logic             disc_wait_q, disc_wait_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic [CNTW-1:0]  frame_cnt_q, frame_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             err_trunc_q, err_trunc_d;
    logic             busy_q, busy_d;
    logic             fifo_ren_s;
    logic             tx_start_s;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            disc_wait_q  <= 1'b0;
            tx_data_q    <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            err_trunc_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            disc_wait_q  <= disc_wait_d;
            tx_data_q    <= tx_data_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            err_trunc_q  <= err_trunc_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic; read and start strobes stay combinational so they land in the same
    // cycle as the condition that allows them.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        disc_wait_d  = disc_wait_q;
        tx_data_d    = tx_data_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        err_trunc_d  = 1'b0;
        fifo_ren_s   = 1'b0;
        tx_start_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && !fifo_empty && !fifo_frame_end) begin
                    state_d    = ST_REQ;
                    byte_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                fifo_ren_s = 1'b1;
                state_d    = ST_WAITV;
            end
            ST_WAITV: begin
                if (fifo_valid) begin
                    tx_data_d = fifo_dout;
                    state_d   = ST_SEND;
                end else begin
                    state_d = ST_WAITV;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_start_s = 1'b1;
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_SEND;
                end
            end
            // tx_ready may still read high for one cycle after tx_start
            ST_HOLD: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!tx_ready) begin
                    state_d = ST_CHECK;
                end else if (fifo_frame_end) begin
                    state_d      = ST_GAP;
                    gap_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + CNTW'(1);
                end else if (byte_cnt_q == BCW'(MAX_LEN)) begin
                    state_d     = ST_DISCARD;
                    disc_wait_d = 1'b0;
                    err_trunc_d = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (disc_wait_q) begin
                    disc_wait_d = !fifo_valid;
                end else if (fifo_frame_end) begin
                    state_d      = ST_GAP;
                    gap_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + CNTW'(1);
                end else if (!fifo_empty) begin
                    fifo_ren_s  = 1'b1;
                    disc_wait_d = 1'b1;
                end else begin
                    disc_wait_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GCW'(GAP_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign fifo_ren   = fifo_ren_s;
    assign tx_start   = tx_start_s;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err_trunc  = err_trunc_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cmd_frame_reader.sv
// Self-checking bench for cmd_frame_reader: frame-level FIFO and UART TX models, a byte
// scoreboard built from the frame/truncation rules, table vectors and random frames.
module tb_cmd_frame_reader;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int GAP     = 8;
    localparam int CNTW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             fifo_empty;
    logic             fifo_frame_end;
    logic             fifo_ren;
    logic             fifo_valid;
    logic [WIDTH-1:0] fifo_dout;
    logic             tx_ready;
    logic             tx_start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             frame_done;
    logic             err_trunc;
    logic [CNTW-1:0]  frame_cnt;

    cmd_frame_reader #(
        .WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .fifo_empty(fifo_empty), .fifo_frame_end(fifo_frame_end), .fifo_ren(fifo_ren),
        .fifo_valid(fifo_valid), .fifo_dout(fifo_dout),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .frame_done(frame_done), .err_trunc(err_trunc), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         len;
        logic [7:0] d [8];
        int         exp_sent;
        int         exp_trunc;
        int         exp_ren;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int         flen_q [$];
    logic [7:0] fbyte_q [$];
    logic [7:0] exp_tx [$];
    int         st_cyc [$];
    int n_ren = 0, n_start = 0, n_done = 0, n_trunc = 0;
    int exp_frames = 0, exp_sent = 0, exp_trunc = 0, exp_reads = 0;
    int byte_t = 10;
    int tx_left = 0;
    int first_ren_cyc = -1;
    logic [7:0] cur_byte = 8'h00;
    logic s_ren, s_start, s_done, s_trunc;
    logic [7:0] s_data, exp_b;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic upd_flags();
        fifo_empty     = (flen_q.size() == 0);
        fifo_frame_end = (flen_q.size() != 0) && (flen_q[0] == 0);
    endtask

    // Reference model: a frame sends min(len, MAX_LEN) bytes, reads all len bytes,
    // truncates when len > MAX_LEN, and always completes once.
    task automatic push_frame(input int len, input logic [7:0] d [8]);
        for (int i = 0; i < len; i++) begin
            fbyte_q.push_back(d[i]);
            if (i < MAX_LEN) exp_tx.push_back(d[i]);
        end
        flen_q.push_back(len);
        exp_frames++;
        exp_reads += len;
        exp_sent  += (len < MAX_LEN) ? len : MAX_LEN;
        if (len > MAX_LEN) exp_trunc++;
        upd_flags();
    endtask

    task automatic checkpoint(input string tag);
        chk({tag, "_sent"}, n_start, exp_sent);
        chk({tag, "_trunc"}, n_trunc, exp_trunc);
        chk({tag, "_done"}, n_done, exp_frames);
        chk({tag, "_reads"}, n_ren, exp_reads);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), exp_frames % (1 << CNTW));
        chk({tag, "_sb_left"}, exp_tx.size(), 0);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_fifo_ren"}, int'(fifo_ren), 0);
        chk({tag, "_tx_start"}, int'(tx_start), 0);
        chk({tag, "_tx_data"}, int'(tx_data), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_err_trunc"}, int'(err_trunc), 0);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    endtask

    task automatic wait_idle(input bit need_empty, input int budget);
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(!busy && tx_ready && (fifo_empty || !need_empty)) && n < budget);
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy=%0d empty=%0d after %0d cycles", busy, fifo_empty, n);
        end
    endtask

    // FIFO and UART TX environment: sample strobes at negedge, respond just after posedge.
    initial begin
        forever begin
            @(negedge clk);
            s_ren   = fifo_ren;
            s_start = tx_start;
            s_done  = frame_done;
            s_trunc = err_trunc;
            s_data  = tx_data;
            if (rst_n) begin
                if (s_ren) begin
                    n_ren++;
                    if (first_ren_cyc < 0) first_ren_cyc = cyc;
                    chk("ren_legal", int'(fifo_empty || fifo_frame_end), 0);
                end
                if (s_start) begin
                    n_start++;
                    st_cyc.push_back(cyc);
                    chk("start_when_ready", int'(tx_ready), 1);
                    if (exp_tx.size() > 0) begin
                        exp_b = exp_tx.pop_front();
                        chk("tx_byte", int'(s_data), int'(exp_b));
                    end else begin
                        chk("tx_unexpected_byte", int'(s_data), -1);
                    end
                    cur_byte = s_data;
                end else if (!tx_ready) begin
                    chk("tx_data_stable", int'(s_data), int'(cur_byte));
                end
                if (s_done) n_done++;
                if (s_trunc) n_trunc++;
            end
            @(posedge clk); #1;
            if (rst_n) begin
                fifo_valid = 1'b0;
                if (s_ren && flen_q.size() > 0 && flen_q[0] > 0) begin
                    fifo_dout  = fbyte_q.pop_front();
                    flen_q[0]  = flen_q[0] - 1;
                    fifo_valid = 1'b1;
                end
                if (s_done && flen_q.size() > 0 && flen_q[0] == 0) void'(flen_q.pop_front());
                if (s_start) begin
                    tx_ready = 1'b0;
                    tx_left  = byte_t;
                end else if (tx_left > 0) begin
                    tx_left--;
                    if (tx_left == 0) tx_ready = 1'b1;
                end
                upd_flags();
            end
        end
    end

    vec_t       tbl [4];
    logic [7:0] d [8];
    int b_start, b_trunc, b_done, b_ren, push_cyc, len, n;

    initial begin
        tbl[0] = '{len: 3, d: '{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   exp_sent: 3, exp_trunc: 0, exp_ren: 3};
        tbl[1] = '{len: 6, d: '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00},
                   exp_sent: 4, exp_trunc: 1, exp_ren: 6};
        tbl[2] = '{len: 1, d: '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   exp_sent: 1, exp_trunc: 0, exp_ren: 1};
        tbl[3] = '{len: 4, d: '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00},
                   exp_sent: 4, exp_trunc: 0, exp_ren: 4};

        rst_n = 1'b0; en = 1'b0; fifo_valid = 1'b0; fifo_dout = 8'h00;
        tx_ready = 1'b1; fifo_empty = 1'b1; fifo_frame_end = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outputs_zero("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        en    = 1'b1;

        // Directed frames: normal, truncated, follow-up after truncation, exactly MAX_LEN
        for (int i = 0; i < 4; i++) begin
            b_start = n_start; b_trunc = n_trunc; b_done = n_done; b_ren = n_ren;
            first_ren_cyc = -1;
            byte_t = 10;
            @(posedge clk); #2;
            push_cyc = cyc;
            push_frame(tbl[i].len, tbl[i].d);
            wait_idle(1'b1, 2000);
            chk("vec_sent", n_start - b_start, tbl[i].exp_sent);
            chk("vec_trunc", n_trunc - b_trunc, tbl[i].exp_trunc);
            chk("vec_done", n_done - b_done, 1);
            chk("vec_reads", n_ren - b_ren, tbl[i].exp_ren);
            if (i == 0) chk("first_ren_latency", first_ren_cyc - push_cyc, 1);
            checkpoint("vec");
        end

        // Back-to-back frames must be separated by at least GAP idle cycles on the line
        st_cyc.delete();
        byte_t = 10;
        @(posedge clk); #2;
        d = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_frame(1, d);
        d = '{8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_frame(2, d);
        wait_idle(1'b1, 2000);
        chk("b2b_starts", st_cyc.size(), 3);
        if (st_cyc.size() >= 2)
            chk("b2b_gap_ok", int'((st_cyc[1] - st_cyc[0] - byte_t - 1) >= GAP), 1);
        chk("b2b_empty", int'(fifo_empty), 1);
        checkpoint("b2b");

        // en dropped mid-frame: current frame finishes, the queued one waits
        b_start = n_start; b_done = n_done; b_ren = n_ren;
        @(posedge clk); #2;
        d = '{8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_frame(3, d);
        d = '{8'hB1, 8'hB2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_frame(2, d);
        n = 0;
        while (n_start == b_start && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        chk("en_first_start_seen", int'(n_start > b_start), 1);
        en = 1'b0;
        wait_idle(1'b0, 2000);
        chk("en_sent", n_start - b_start, 3);
        chk("en_done", n_done - b_done, 1);
        chk("en_second_queued", int'(fifo_empty), 0);
        repeat (30) @(posedge clk);
        #2;
        chk("en_busy_stays_0", int'(busy), 0);
        chk("en_no_reads", n_ren - b_ren, 3);
        en = 1'b1;
        wait_idle(1'b1, 2000);
        chk("en_resume_sent", n_start - b_start, 5);
        checkpoint("en");

        // Random frames, including oversize ones; frame_cnt wraps past 2^CNTW-1
        for (int k = 0; k < 12; k++) begin
            byte_t = $urandom_range(1, 12);
            @(posedge clk); #2;
            len = $urandom_range(1, 7);
            for (int j = 0; j < 8; j++) d[j] = 8'($urandom);
            push_frame(len, d);
            if ($urandom_range(0, 1) == 1) begin
                len = $urandom_range(1, 7);
                for (int j = 0; j < 8; j++) d[j] = 8'($urandom);
                push_frame(len, d);
            end
            wait_idle(1'b1, 3000);
            checkpoint("rand");
        end

        // Reset while byte 2 of a frame sits in SEND
        byte_t = 10;
        b_ren = n_ren;
        @(posedge clk); #2;
        d = '{8'h61, 8'h62, 8'h63, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_frame(3, d);
        n = 0;
        while (n_ren - b_ren < 2 && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        chk("rst_second_read_seen", n_ren - b_ren, 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        flen_q.delete(); fbyte_q.delete(); exp_tx.delete();
        fifo_valid = 1'b0; tx_ready = 1'b1; tx_left = 0;
        upd_flags();
        n_ren = 0; n_start = 0; n_done = 0; n_trunc = 0;
        exp_frames = 0; exp_sent = 0; exp_trunc = 0; exp_reads = 0;
        @(negedge clk); #1;
        outputs_zero("midrst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        d = '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_frame(1, d);
        wait_idle(1'b1, 2000);
        chk("post_rst_sent", n_start, 1);
        chk("post_rst_frame_cnt", int'(frame_cnt), 1);
        checkpoint("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
